hash_squeeze_buffer: RTL
========================

Name: hash_squeeze_buffer

Overview:
Parametrised squeeze-side output buffer for the Keccak/SHAKE hash core. Collects the rate lanes of the final permutation round, which arrive as 8-bit lane slices over 8 sub-rounds. Streams them out as OUT_W-bit words over a valid/ready handshake. Supports runtime SHAKE128/SHAKE256 rate selection and multi-block squeeze: it requests further permutations until the requested word count has been delivered.

Parameters:
LANE_W, 64, Keccak lane width; fixed at 64, slices are LANE_W/8 = 8 per lane
CI_W, 200, width of the round-engine slice bus (25 lanes x 8 bits)
MAX_LANES, 21, buffer depth in lanes (SHAKE128 rate, 1344 bits)
OUT_W, 64, output word width; legal values 64 or 32
CNT_W, 16, width of the requested-word counter

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a squeeze of req_words words
mode  in  1  0 = SHAKE128 (21 lanes/block), 1 = SHAKE256 (17 lanes/block); sampled on start
req_words  in  CNT_W  total output words to deliver; sampled on start
slice_vld  in  1  ci_out carries a valid final-round slice
slice_idx  in  3  sub-round index of the slice (7 first, 0 last in normal order)
ci_out  in  CI_W  slice bus, MSB-first; lane j byte = ci_out[CI_W-1-8j -: 8]
perm_req  out  1  one-cycle pulse requesting the next squeeze permutation
out_data  out  OUT_W  output word; all zeros when out_valid = 0
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the word
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse when the last requested word is accepted
err  out  1  sticky; slice protocol violation; cleared by start

Behaviour:
- Reset: state IDLE; buffer, slice mask and counters zero; all outputs 0.
- FSM has three states: IDLE, LOAD, DRAIN.
- IDLE, start=1:
  - Latch mode and req_words, clear err and the slice mask.
  - If req_words = 0, pulse done next cycle and stay in IDLE.
  - Otherwise go to LOAD. The first permutation is triggered by the absorber; no perm_req is issued.
- LOAD, slice_vld=1:
  - For each lane j < nlanes(mode), write ci_out lane byte j into buffer lane j at byte position 7-slice_idx. Byte 0 is the lane MSB, so slice 7 lands at lane bits [63:56].
  - Set mask[slice_idx]. Slices are accepted in any order.
  - A repeated slice_idx overwrites the byte and sets err.
  - Lanes at and above nlanes are not written.
- LOAD: when the mask becomes all ones, go to DRAIN on the next cycle. Last slice accepted at cycle t gives out_valid=1 at t+1.
- DRAIN:
  - out_data = buffer head word (lane 0 first; for OUT_W=32, upper half then lower half).
  - On out_valid & out_ready: shift the buffer by OUT_W (zero fill), decrement the remaining count, increment the block word index.
  - Data and valid are held stable while out_ready=0.
  - Block size is nlanes*LANE_W/OUT_W words (21/17 at OUT_W=64; 42/34 at OUT_W=32).
- Handshake on the last requested word: pulse done, go to IDLE, out_valid=0 next cycle. A partial block is discarded.
- Handshake on the last word of a block while words remain: pulse perm_req, clear the mask, go to LOAD.
- slice_vld in DRAIN or IDLE: ignored and sets err.
- start while busy: ignored.
- rst_n low mid-operation: asynchronous return to the reset state; the partial block is lost.

Optional Feature:
Macro HASH_SQZ_LE_OUT_EN.
- Defined: each output word is byte-reversed before out_data (Keccak little-endian lane order; at OUT_W=32 the reversal applies within each 32-bit word after lane split).
- Undefined: MSB-first order as buffered.
- Internal state and timing are identical in both cases.

Decomposition:
- Shared package hash_pkg holds:
  - state enum SQZ_IDLE/SQZ_LOAD/SQZ_DRAIN
  - mode constants and rate constants LANES_SHAKE128=21, LANES_SHAKE256=17
  - SLICES_PER_LANE=8
- One natural sub-module, hash_lane_slice_writer: combinational byte-lane write-enable and data mapping from (slice_idx, ci_out, nlanes) into the buffer.

Test Plan:
- SHAKE128, req_words=21, slices 7..0 with lane j byte = j, out_ready=1: 21 words out, word j = 64'h{8{j}}, done on word 21, no perm_req, err=0.
- SHAKE256, req_words=40: perm_req pulses after words 17 and 34. Third block: only 6 words delivered, then done and IDLE.
- Back-pressure: out_ready toggles 1-0-0-1 during DRAIN; out_data is stable while stalled, no word is lost or duplicated, and the total count is exact.
- Slices in order 0..7 give the same buffer as 7..0. Slice 3 sent twice: err=1, and err clears on the next start.
- OUT_W=32 build, lane 0 = 64'h0011223344556677: words 32'h00112233 then 32'h44556677. With HASH_SQZ_LE_OUT_EN: 32'h33221100 then 32'h77665544.
- rst_n asserted mid-DRAIN after 5 words: outputs 0 immediately. A new start with req_words=0 gives done the next cycle.

Source files
------------

// File: rtl/hash_pkg.sv
// ---------------------------------------------------------------------------
// hash_pkg
// Shared definitions for the Keccak/SHAKE squeeze-side output buffer:
// FSM state encoding, SHAKE mode codes, per-mode rate (lanes per block)
// and the number of 8-bit slices that make up one 64-bit lane.
// ---------------------------------------------------------------------------
package hash_pkg;

    typedef enum logic [1:0] {
        SQZ_IDLE  = 2'd0,
        SQZ_LOAD  = 2'd1,
        SQZ_DRAIN = 2'd2
    } sqz_state_t;

    localparam logic MODE_SHAKE128 = 1'b0;
    localparam logic MODE_SHAKE256 = 1'b1;

    localparam int LANES_SHAKE128  = 21;
    localparam int LANES_SHAKE256  = 17;
    localparam int SLICES_PER_LANE = 8;

    // Rate of the selected SHAKE variant, in lanes per squeeze block.
    function automatic logic [4:0] nlanes_of(input logic mode);
        return (mode == MODE_SHAKE256) ? 5'(LANES_SHAKE256) : 5'(LANES_SHAKE128);
    endfunction

endpackage

// File: rtl/hash_lane_slice_writer.sv
// ---------------------------------------------------------------------------
// hash_lane_slice_writer
// Combinational mapping of one final-round slice onto the squeeze buffer.
// The buffer holds lane 0 in its most significant LANE_W bits; within a
// lane byte 0 is the MSB, and slice s lands in byte 7-s.
//
// Ports:
//   slice_idx  in   3          sub-round index of the slice
//   ci_out     in   CI_W       slice bus, lane j byte = ci_out[CI_W-1-8j -: 8]
//   nlanes     in   5          lanes in the current rate; higher lanes untouched
//   wr_en      out  BUF_W      per-bit write enable into the buffer
//   wr_data    out  BUF_W      data aligned to wr_en
// ---------------------------------------------------------------------------
module hash_lane_slice_writer
    import hash_pkg::*;
#(
    parameter int LANE_W    = 64,
    parameter int CI_W      = 200,
    parameter int MAX_LANES = 21
) (
    input  logic [2:0]                  slice_idx,
    input  logic [CI_W-1:0]             ci_out,
    input  logic [4:0]                  nlanes,
    output logic [MAX_LANES*LANE_W-1:0] wr_en,
    output logic [MAX_LANES*LANE_W-1:0] wr_data
);

    localparam int BUF_W = MAX_LANES * LANE_W;

    int byte_pos;
    int hi;

    always_comb begin
        wr_en    = '0;
        wr_data  = '0;
        byte_pos = (SLICES_PER_LANE - 1) - int'(slice_idx);
        hi       = 0;
        for (int j = 0; j < MAX_LANES; j++) begin
            if (j < int'(nlanes)) begin
                hi = BUF_W - 1 - LANE_W * j - 8 * byte_pos;
                wr_en[hi -: 8]   = 8'hFF;
                wr_data[hi -: 8] = ci_out[CI_W-1-8*j -: 8];
            end
        end
    end

endmodule

// File: rtl/hash_squeeze_buffer.sv
// ---------------------------------------------------------------------------
// hash_squeeze_buffer
// Squeeze-side output buffer of the Keccak/SHAKE core. Gathers the rate lanes
// of the final permutation round (8 byte-slices, any order), then streams
// them out as OUT_W-bit words over valid/ready. When a block is exhausted and
// words remain, perm_req asks for another permutation and loading resumes.
//
// Optional build macro: HASH_SQZ_LE_OUT_EN -- byte-reverse each output word
// (little-endian lane order). Internal state and timing are unchanged.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   start, mode, req_words  arm a squeeze (mode/req_words sampled on start)
//   slice_vld, slice_idx, ci_out  final-round slice input
//   perm_req              one-cycle request for the next permutation
//   out_data, out_valid, out_ready  output word stream
//   busy, done, err       status (err sticky until next start)
// ---------------------------------------------------------------------------
module hash_squeeze_buffer
    import hash_pkg::*;
#(
    parameter int LANE_W    = 64,
    parameter int CI_W      = 200,
    parameter int MAX_LANES = 21,
    parameter int OUT_W     = 64,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [CNT_W-1:0] req_words,
    input  logic             slice_vld,
    input  logic [2:0]       slice_idx,
    input  logic [CI_W-1:0]  ci_out,
    output logic             perm_req,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int BUF_W = MAX_LANES * LANE_W;
    localparam int WPL   = LANE_W / OUT_W;

    sqz_state_t       state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [7:0]       mask_q, mask_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [6:0]       widx_q, widx_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic             perm_q, perm_d;

    logic [4:0]       nlanes;
    logic [6:0]       blk_words;
    logic [7:0]       mask_set;
    logic [BUF_W-1:0] wr_en, wr_data;
    logic [OUT_W-1:0] head;

    function automatic logic [OUT_W-1:0] byte_rev(input logic [OUT_W-1:0] w);
        logic [OUT_W-1:0] r;
        for (int b = 0; b < OUT_W / 8; b++) begin
            r[8*b +: 8] = w[OUT_W-8-8*b +: 8];
        end
        return r;
    endfunction

    assign nlanes    = nlanes_of(mode_q);
    assign blk_words = 7'(int'(nlanes) * WPL);
    assign mask_set  = mask_q | (8'b1 << slice_idx);
    assign head      = buf_q[BUF_W-1 -: OUT_W];

    hash_lane_slice_writer #(
        .LANE_W    (LANE_W),
        .CI_W      (CI_W),
        .MAX_LANES (MAX_LANES)
    ) u_writer (
        .slice_idx (slice_idx),
        .ci_out    (ci_out),
        .nlanes    (nlanes),
        .wr_en     (wr_en),
        .wr_data   (wr_data)
    );

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        mask_d  = mask_q;
        rem_d   = rem_q;
        widx_d  = widx_q;
        mode_d  = mode_q;
        err_d   = err_q;
        done_d  = 1'b0;
        perm_d  = 1'b0;
        case (state_q)
            SQZ_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    rem_d  = req_words;
                    err_d  = 1'b0;
                    mask_d = '0;
                    widx_d = '0;
                    // The absorber fires the first permutation itself.
                    if (req_words == '0) done_d  = 1'b1;
                    else                 state_d = SQZ_LOAD;
                end
                if (slice_vld) err_d = 1'b1;
            end
            SQZ_LOAD: begin
                if (slice_vld) begin
                    buf_d  = (buf_q & ~wr_en) | (wr_data & wr_en);
                    mask_d = mask_set;
                    if (mask_q[slice_idx]) err_d = 1'b1;
                    if (mask_set == 8'hFF) state_d = SQZ_DRAIN;
                end
            end
            SQZ_DRAIN: begin
                if (slice_vld) err_d = 1'b1;
                if (out_ready) begin
                    buf_d  = buf_q << OUT_W;
                    rem_d  = rem_q - CNT_W'(1);
                    widx_d = widx_q + 7'd1;
                    if (rem_q == CNT_W'(1)) begin
                        // Any unread tail of the block is dropped.
                        done_d  = 1'b1;
                        state_d = SQZ_IDLE;
                    end else if (widx_q == blk_words - 7'd1) begin
                        perm_d  = 1'b1;
                        mask_d  = '0;
                        widx_d  = '0;
                        state_d = SQZ_LOAD;
                    end
                end
            end
            default: state_d = SQZ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SQZ_IDLE;
            buf_q   <= '0;
            mask_q  <= '0;
            rem_q   <= '0;
            widx_q  <= '0;
            mode_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            perm_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            rem_q   <= rem_d;
            widx_q  <= widx_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
            done_q  <= done_d;
            perm_q  <= perm_d;
        end
    end

    assign out_valid = (state_q == SQZ_DRAIN);
`ifdef HASH_SQZ_LE_OUT_EN
    assign out_data  = out_valid ? byte_rev(head) : '0;
`else
    assign out_data  = out_valid ? head : '0;
`endif
    assign busy      = (state_q != SQZ_IDLE);
    assign done      = done_q;
    assign perm_req  = perm_q;
    assign err       = err_q;

endmodule
